// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: free-running 4-stage YCbCr (8:8:8, full range) to RGB888 converter.
// Coefficients are scaled by 256: R = Y + 1.402cr, G = Y - 0.344cb - 0.714cr,
// B = Y + 1.772cb. Results are clamped to 0..255. Pixels that needed clamping
// are counted per frame. The count is published on each rising edge of the
// delayed vsync.
//
// Handshake: there is no flow control. ycbcr_clken/ycbcr_valid are plain
// sideband bits. The pipeline advances on every clock. Each sideband bit
// emerges exactly 4 cycles later, aligned with the data it came in with.
module ycbcr2rgb #(
  parameter int ROUND_EN   = 1,
  parameter int ZERO_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ycbcr_vsync,
  input  logic        ycbcr_clken,
  input  logic        ycbcr_valid,
  input  logic [23:0] ycbcr_data,
  output logic        rgb_vsync,
  output logic        rgb_clken,
  output logic        rgb_valid,
  output logic [23:0] rgb_data,
  output logic [15:0] sat_count
);

  localparam logic signed [18:0] RND    = (ROUND_EN != 0) ? 19'sd128 : 19'sd0;
  localparam logic signed [18:0] C_RCR  = 19'sd359;
  localparam logic signed [18:0] C_GCB  = 19'sd88;
  localparam logic signed [18:0] C_GCR  = 19'sd183;
  localparam logic signed [18:0] C_BCB  = 19'sd454;

  // Sign-extend a centred 9-bit chroma value to the 19-bit datapath width.
  function automatic logic signed [18:0] sx(input logic signed [8:0] v);
    sx = {{10{v[8]}}, v};
  endfunction

  // Clamp an already-shifted channel value. Returns {clamped_flag, byte}.
  function automatic logic [8:0] clamp8(input logic signed [18:0] v);
    if (v[18])
      clamp8 = {1'b1, 8'd0};
    else if (v[17:8] != 10'd0)
      clamp8 = {1'b1, 8'hFF};
    else
      clamp8 = {1'b0, v[7:0]};
  endfunction

  logic [7:0] y_in, cb_in, cr_in;
  assign y_in  = ycbcr_data[23:16];
  assign cb_in = ycbcr_data[15:8];
  assign cr_in = ycbcr_data[7:0];

  // Stage registers
  logic signed [18:0] s1_y;
  logic signed [8:0]  s1_cb, s1_cr;
  logic signed [18:0] s2_y, s2_rcr, s2_gcb, s2_gcr, s2_bcb;
  logic signed [18:0] s3_r, s3_g, s3_b;
  logic [23:0]        s4_data;
  logic               s4_clamp;

  // Sideband delay lines; bit 3 is the output/S4-aligned tap
  logic [3:0] vsync_sr, clken_sr, valid_sr;

  // S1: scale luma and centre chroma around zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_y  <= '0;
      s1_cb <= '0;
      s1_cr <= '0;
    end else begin
      s1_y  <= signed'({3'b000, y_in, 8'h00});
      s1_cb <= signed'({1'b0, cb_in}) - 9'sd128;
      s1_cr <= signed'({1'b0, cr_in}) - 9'sd128;
    end
  end

  // S2: the four chroma products, with luma carried alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_y   <= '0;
      s2_rcr <= '0;
      s2_gcb <= '0;
      s2_gcr <= '0;
      s2_bcb <= '0;
    end else begin
      s2_y   <= s1_y;
      s2_rcr <= sx(s1_cr) * C_RCR;
      s2_gcb <= sx(s1_cb) * C_GCB;
      s2_gcr <= sx(s1_cr) * C_GCR;
      s2_bcb <= sx(s1_cb) * C_BCB;
    end
  end

  // S3: per-channel sums including the rounding constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_r <= '0;
      s3_g <= '0;
      s3_b <= '0;
    end else begin
      s3_r <= s2_y + s2_rcr + RND;
      s3_g <= s2_y - s2_gcb - s2_gcr + RND;
      s3_b <= s2_y + s2_bcb + RND;
    end
  end

  logic signed [18:0] sh_r, sh_g, sh_b;
  logic [8:0]         cl_r, cl_g, cl_b;
  assign sh_r = s3_r >>> 8;
  assign sh_g = s3_g >>> 8;
  assign sh_b = s3_b >>> 8;
  assign cl_r = clamp8(sh_r);
  assign cl_g = clamp8(sh_g);
  assign cl_b = clamp8(sh_b);

  // S4: clamp to 8 bits and note whether any channel saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_data  <= '0;
      s4_clamp <= 1'b0;
    end else begin
      s4_data  <= {cl_r[7:0], cl_g[7:0], cl_b[7:0]};
      s4_clamp <= cl_r[8] | cl_g[8] | cl_b[8];
    end
  end

  // Sideband shift registers, 4 deep to match the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_sr <= '0;
      clken_sr <= '0;
      valid_sr <= '0;
    end else begin
      vsync_sr <= {vsync_sr[2:0], ycbcr_vsync};
      clken_sr <= {clken_sr[2:0], ycbcr_clken};
      valid_sr <= {valid_sr[2:0], ycbcr_valid};
    end
  end

  assign rgb_vsync = vsync_sr[3];
  assign rgb_clken = clken_sr[3];
  assign rgb_valid = valid_sr[3];
  assign rgb_data  = ((ZERO_BLANK != 0) && !rgb_clken) ? 24'd0 : s4_data;

  logic        vs_prev;
  logic [15:0] acc;
  logic        vs_rise, count_pix;
  assign vs_rise   = vsync_sr[3] & ~vs_prev;
  assign count_pix = valid_sr[3] & s4_clamp;

  // Per-frame clamp accumulator. On a frame boundary the count is published
  // and a pixel counted on that same cycle opens the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b0;
      acc       <= '0;
      sat_count <= '0;
    end else begin
      vs_prev <= vsync_sr[3];
      if (vs_rise) begin
        sat_count <= acc;
        acc       <= count_pix ? 16'd1 : 16'd0;
      end else if (count_pix && (acc != 16'hFFFF)) begin
        acc <= acc + 16'd1;
      end
    end
  end

endmodule
